// File: rtl/a23_cache_flush_ctrl.sv
// A23 cache flush controller.
// Walks every line of the tag RAM issuing an all-ways invalidate, either on an
// explicit CP15 flush request or when an enabled access touches a 2MB region
// marked disruptive. Requests arriving while busy merge into a single pending
// flush that starts straight after the current one completes.

module a23_cache_flush_ctrl #(
  parameter int unsigned CACHE_LINES = 256,
  parameter int unsigned CACHE_WAYS  = 4,
  parameter int unsigned LINE_W      = $clog2(CACHE_LINES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush_req,
  input  logic                  i_cache_enable,
  input  logic [31:0]           i_disruptive_area,
  input  logic                  i_access_valid,
  input  logic [31:0]           i_access_addr,
  input  logic                  i_mem_idle,
  input  logic                  i_tag_rdy,
  output logic                  o_stall,
  output logic                  o_tag_wr_en,
  output logic [LINE_W-1:0]     o_tag_wr_addr,
  output logic [CACHE_WAYS-1:0] o_tag_wr_way_mask,
  output logic                  o_flush_done,
  output logic                  o_busy,
  output logic [15:0]           o_flush_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(CACHE_LINES - 1);

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              pending_q, pending_d;
  logic [15:0]       flush_count_q, flush_count_d;

  logic area_hit;
  logic trigger;

  // Only address bits [25:21] select the 2MB region; the rest are irrelevant here.
  logic unused_addr;
  assign unused_addr = ^{i_access_addr[31:26], i_access_addr[20:0]};

  // Trigger decode: explicit flush always wins, region hits only with the cache on.
  always_comb begin
    area_hit = i_disruptive_area[i_access_addr[25:21]];
    trigger  = i_flush_req | (i_cache_enable & i_access_valid & area_hit);
  end

  // Next-state logic for the flush sequencer, line counter, pending flag and count.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    pending_d     = pending_q;
    flush_count_d = flush_count_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        pending_d = pending_q | trigger;
        // Wait for outstanding fills/writes so none land after their line is invalidated.
        if (i_mem_idle) begin
          state_d = FLUSH;
          line_d  = '0;
        end
      end

      FLUSH: begin
        pending_d = pending_q | trigger;
        if (i_tag_rdy) begin
          if (line_q == LAST_LINE) begin
            // Counter is left on the last line rather than wrapping.
            state_d = DONE;
            if (flush_count_q != 16'hFFFF) begin
              flush_count_d = flush_count_q + 16'd1;
            end
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end

      DONE: begin
        // A trigger landing in DONE itself is folded into the pending request.
        pending_d = 1'b0;
        if (pending_q | trigger) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; reset aborts any flush in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      pending_q     <= 1'b0;
      flush_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      pending_q     <= pending_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Output decode; stall is combinational so the triggering access is frozen immediately.
  always_comb begin
    o_busy            = (state_q != IDLE);
    o_stall           = (state_q != IDLE) | trigger;
    o_tag_wr_en       = (state_q == FLUSH);
    o_tag_wr_addr     = o_tag_wr_en ? line_q : '0;
    o_tag_wr_way_mask = {CACHE_WAYS{o_tag_wr_en}};
    o_flush_done      = (state_q == DONE);
    o_flush_count     = flush_count_q;
  end

endmodule
